// File: rtl/toy_bpu_rob_queue.sv
// In-order fetch reorder buffer: entries are preallocated at fetch issue, filled by in-order
// icache acks, qualified by out-of-order BP2 results and retired to the fetch filter in order.
module toy_bpu_rob_queue #(
    parameter int DEPTH            = 8,
    parameter int FETCH_DATA_WIDTH = 256,
    parameter int ADDR_WIDTH       = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_alloc_vld,
    input  logic [ADDR_WIDTH-1:0]               i_alloc_pc,
    output logic                                o_alloc_rdy,
    output logic [$clog2(DEPTH)-1:0]            o_alloc_id,
    input  logic                                i_icache_ack_vld,
    input  logic [FETCH_DATA_WIDTH-1:0]         i_icache_ack_pld,
    input  logic                                i_bp2_vld,
    input  logic [$clog2(DEPTH)-1:0]            i_bp2_id,
    input  logic                                i_bp2_flush,
    input  logic [$clog2(DEPTH)-1:0]            i_bp2_flush_id,
    input  logic                                i_fe_ctrl_flush,
    output logic                                o_out_vld,
    output logic [ADDR_WIDTH-1:0]               o_out_pc,
    output logic [FETCH_DATA_WIDTH-1:0]         o_out_pld,
    input  logic                                i_out_rdy,
    output logic [$clog2(DEPTH):0]              o_cnt,
    output logic [$clog2(DEPTH):0]              o_stale_cnt
);

    localparam int IDW = $clog2(DEPTH);

    // Handshakes: a transfer happens on a cycle where valid && ready are both high at the
    // clock edge; a valid source holds its payload stable until that cycle. Icache acks
    // have no ready: they are always accepted, one per issued allocation.

    logic [DEPTH-1:0]            r_busy;
    logic [DEPTH-1:0]            r_has_data;
    logic [DEPTH-1:0]            r_has_bp2;
    logic [DEPTH-1:0]            r_inv;
    logic [ADDR_WIDTH-1:0]       r_pc  [DEPTH];
    logic [FETCH_DATA_WIDTH-1:0] r_pld [DEPTH];
    logic [IDW-1:0]              r_head;
    logic [IDW-1:0]              r_tail;
    logic [IDW-1:0]              r_ack_ptr;
    logic [IDW:0]                r_cnt;
    logic [IDW:0]                r_stale_cnt;

    logic [IDW+1:0]              w_occupancy;
    logic                        w_alloc_rdy;
    logic                        w_alloc_fire;
    logic                        w_stale_ack;
    logic                        w_fill_ack;
    logic                        w_ack_waiting;
    logic                        w_head_ready;
    logic                        w_out_vld;
    logic                        w_pop;
    logic [DEPTH-1:0]            w_wait_mask;
    logic [DEPTH-1:0]            w_squash;
    logic [IDW:0]                w_n_waiting;
    logic [IDW-1:0]              w_flush_age;

    // Readiness is derived from registered counts only, so a pop never raises it in the same cycle.
    assign w_occupancy  = {1'b0, r_cnt} + {1'b0, r_stale_cnt};
    assign w_alloc_rdy  = w_occupancy < (IDW+2)'(DEPTH);
    assign w_alloc_fire = i_alloc_vld && w_alloc_rdy;

    assign w_stale_ack   = i_icache_ack_vld && (r_stale_cnt != '0);
    assign w_fill_ack    = i_icache_ack_vld && (r_stale_cnt == '0);
    assign w_ack_waiting = r_busy[r_ack_ptr] && !r_has_data[r_ack_ptr];

    assign w_head_ready = r_busy[r_head] && r_has_data[r_head];
    assign w_out_vld    = w_head_ready && r_has_bp2[r_head] && !r_inv[r_head];
    assign w_pop        = w_head_ready && (r_inv[r_head] || (r_has_bp2[r_head] && i_out_rdy));

    assign w_wait_mask = r_busy & ~r_has_data;
    assign w_flush_age = i_bp2_flush_id - r_head;

    // Age is measured from head so a full queue (tail == head) still orders entries correctly.
    always_comb begin
        w_n_waiting = '0;
        w_squash    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_n_waiting = w_n_waiting + (IDW+1)'(w_wait_mask[i]);
            w_squash[i] = i_bp2_flush && r_busy[i] && (IDW'(IDW'(i) - r_head) > w_flush_age);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= '0;
            r_has_data  <= '0;
            r_has_bp2   <= '0;
            r_inv       <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_ack_ptr   <= '0;
            r_cnt       <= '0;
            r_stale_cnt <= '0;
        end else if (i_fe_ctrl_flush) begin
            r_busy      <= '0;
            r_has_data  <= '0;
            r_has_bp2   <= '0;
            r_inv       <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_ack_ptr   <= '0;
            r_cnt       <= '0;
            r_stale_cnt <= r_stale_cnt + w_n_waiting + (IDW+1)'(w_alloc_fire)
                           - (IDW+1)'(i_icache_ack_vld);
        end else begin
            r_inv <= r_inv | w_squash;
            if (w_alloc_fire) begin
                r_busy[r_tail]     <= 1'b1;
                r_has_data[r_tail] <= 1'b0;
                r_has_bp2[r_tail]  <= 1'b0;
                r_inv[r_tail]      <= 1'b0;
                r_tail             <= r_tail + 1'b1;
            end
            if (w_fill_ack) begin
                r_has_data[r_ack_ptr] <= 1'b1;
                r_ack_ptr             <= r_ack_ptr + 1'b1;
            end
            if (i_bp2_vld && r_busy[i_bp2_id]) begin
                r_has_bp2[i_bp2_id] <= 1'b1;
            end
            if (w_pop) begin
                r_busy[r_head]     <= 1'b0;
                r_has_data[r_head] <= 1'b0;
                r_has_bp2[r_head]  <= 1'b0;
                r_inv[r_head]      <= 1'b0;
                r_head             <= r_head + 1'b1;
            end
            r_cnt       <= r_cnt + (IDW+1)'(w_alloc_fire) - (IDW+1)'(w_pop);
            r_stale_cnt <= r_stale_cnt - (IDW+1)'(w_stale_ack);
        end
    end

    // Payload storage needs no reset: it is only visible behind a set flag.
    always_ff @(posedge clk) begin
        if (w_alloc_fire && !i_fe_ctrl_flush) begin
            r_pc[r_tail] <= i_alloc_pc;
        end
        if (w_fill_ack) begin
            r_pld[r_ack_ptr] <= i_icache_ack_pld;
        end
    end

    assign o_alloc_rdy = w_alloc_rdy;
    assign o_alloc_id  = r_tail;
    assign o_out_vld   = w_out_vld;
    assign o_out_pc    = w_out_vld ? r_pc[r_head]  : '0;
    assign o_out_pld   = w_out_vld ? r_pld[r_head] : '0;
    assign o_cnt       = r_cnt;
    assign o_stale_cnt = r_stale_cnt;

    a_ack_has_target: assert property (@(posedge clk) disable iff (!rst_n)
        (i_icache_ack_vld && (r_stale_cnt == '0)) |-> w_ack_waiting);

endmodule

// File: tb/tb_toy_bpu_rob_queue.sv
// Directed bench for toy_bpu_rob_queue: drivers push expected retirements into a queue,
// a negedge monitor pops and compares every accepted output.
module tb_toy_bpu_rob_queue;

    localparam int DEPTH = 8;
    localparam int FDW   = 256;
    localparam int AW    = 32;
    localparam int IDW   = 3;

    logic            clk;
    logic            rst_n;
    logic            i_alloc_vld;
    logic [AW-1:0]   i_alloc_pc;
    logic            o_alloc_rdy;
    logic [IDW-1:0]  o_alloc_id;
    logic            i_icache_ack_vld;
    logic [FDW-1:0]  i_icache_ack_pld;
    logic            i_bp2_vld;
    logic [IDW-1:0]  i_bp2_id;
    logic            i_bp2_flush;
    logic [IDW-1:0]  i_bp2_flush_id;
    logic            i_fe_ctrl_flush;
    logic            o_out_vld;
    logic [AW-1:0]   o_out_pc;
    logic [FDW-1:0]  o_out_pld;
    logic            i_out_rdy;
    logic [IDW:0]    o_cnt;
    logic [IDW:0]    o_stale_cnt;

    logic [AW+FDW-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    toy_bpu_rob_queue #(.DEPTH(DEPTH), .FETCH_DATA_WIDTH(FDW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_alloc_vld(i_alloc_vld), .i_alloc_pc(i_alloc_pc),
        .o_alloc_rdy(o_alloc_rdy), .o_alloc_id(o_alloc_id),
        .i_icache_ack_vld(i_icache_ack_vld), .i_icache_ack_pld(i_icache_ack_pld),
        .i_bp2_vld(i_bp2_vld), .i_bp2_id(i_bp2_id),
        .i_bp2_flush(i_bp2_flush), .i_bp2_flush_id(i_bp2_flush_id),
        .i_fe_ctrl_flush(i_fe_ctrl_flush),
        .o_out_vld(o_out_vld), .o_out_pc(o_out_pc), .o_out_pld(o_out_pld),
        .i_out_rdy(i_out_rdy), .o_cnt(o_cnt), .o_stale_cnt(o_stale_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [FDW-1:0] mk_pld(input logic [AW-1:0] pc);
        return {8{pc ^ 32'hA5A5_0000}};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_alloc_vld      = 1'b0;
        i_alloc_pc       = '0;
        i_icache_ack_vld = 1'b0;
        i_icache_ack_pld = '0;
        i_bp2_vld        = 1'b0;
        i_bp2_id         = '0;
        i_bp2_flush      = 1'b0;
        i_bp2_flush_id   = '0;
        i_fe_ctrl_flush  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        i_out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic do_alloc(input logic [AW-1:0] pc, input bit expect_out);
        i_alloc_vld = 1'b1;
        i_alloc_pc  = pc;
        if (expect_out) exp_q.push_back({pc, mk_pld(pc)});
        tick();
        i_alloc_vld = 1'b0;
    endtask

    task automatic do_ack(input logic [FDW-1:0] pld);
        i_icache_ack_vld = 1'b1;
        i_icache_ack_pld = pld;
        tick();
        i_icache_ack_vld = 1'b0;
    endtask

    task automatic do_bp2(input logic [IDW-1:0] id);
        i_bp2_vld = 1'b1;
        i_bp2_id  = id;
        tick();
        i_bp2_vld = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 60; c++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && o_out_vld && i_out_rdy) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL out_unexpected: got pc 0x%0h with nothing expected", o_out_pc);
            end else begin
                logic [AW+FDW-1:0] exp_item;
                exp_item = exp_q.pop_front();
                if ({o_out_pc, o_out_pld} !== exp_item) begin
                    n_errors++;
                    $display("FAIL out_entry: got pc 0x%0h pld 0x%0h expected pc 0x%0h pld 0x%0h",
                             o_out_pc, o_out_pld, exp_item[AW+FDW-1:FDW], exp_item[FDW-1:0]);
                end
            end
        end
    end

    initial begin
        do_reset();
        check("rst_out_vld",   64'(o_out_vld),   64'd0);
        check("rst_out_pc",    64'(o_out_pc),    64'd0);
        check("rst_out_pld",   64'(o_out_pld == '0), 64'd1);
        check("rst_alloc_rdy", 64'(o_alloc_rdy), 64'd1);
        check("rst_alloc_id",  64'(o_alloc_id),  64'd0);
        check("rst_cnt",       64'(o_cnt),       64'd0);
        check("rst_stale",     64'(o_stale_cnt), 64'd0);

        // 1: out-of-order BP2 results, in-order retirement
        do_alloc(32'h100, 1'b1);
        do_alloc(32'h120, 1'b1);
        do_alloc(32'h140, 1'b1);
        check("t1_alloc_id", 64'(o_alloc_id), 64'd3);
        do_ack(mk_pld(32'h100));
        do_ack(mk_pld(32'h120));
        do_ack(mk_pld(32'h140));
        do_bp2(3'd2);
        check("t1_wait_bp2", 64'(o_out_vld), 64'd0);
        do_bp2(3'd0);
        check("t1_latency_vld", 64'(o_out_vld), 64'd1);
        check("t1_latency_pc",  64'(o_out_pc),  64'h100);
        do_bp2(3'd1);
        drain("t1_drain");
        tick();
        check("t1_cnt_empty", 64'(o_cnt), 64'd0);

        // 2: fill to DEPTH with filter stalled, tail wraps, one pop reopens alloc
        do_reset();
        i_out_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) do_alloc(32'h200 + 32'(i) * 32'h20, 1'b1);
        check("t2_full_rdy", 64'(o_alloc_rdy), 64'd0);
        check("t2_full_cnt", 64'(o_cnt),       64'd8);
        check("t2_tail_wrap", 64'(o_alloc_id), 64'd0);
        for (int i = 0; i < DEPTH; i++) do_ack(mk_pld(32'h200 + 32'(i) * 32'h20));
        for (int i = 0; i < DEPTH; i++) do_bp2(IDW'(i));
        check("t2_head_vld", 64'(o_out_vld), 64'd1);
        check("t2_head_pc",  64'(o_out_pc),  64'h200);
        i_alloc_vld = 1'b1;
        i_alloc_pc  = 32'hDEAD;
        tick();
        i_alloc_vld = 1'b0;
        check("t2_ignored_alloc", 64'(o_cnt), 64'd8);
        check("t2_hold_pc", 64'(o_out_pc), 64'h200);
        i_out_rdy = 1'b1;
        check("t2_no_comb_rdy", 64'(o_alloc_rdy), 64'd0);
        tick();
        i_out_rdy = 1'b0;
        check("t2_rdy_after_pop", 64'(o_alloc_rdy), 64'd1);
        check("t2_cnt_after_pop", 64'(o_cnt),       64'd7);
        i_out_rdy = 1'b1;
        drain("t2_drain");

        // 3: front-end flush with in-flight acks and a same-cycle alloc
        do_reset();
        do_alloc(32'h300, 1'b0);
        do_alloc(32'h320, 1'b0);
        do_alloc(32'h340, 1'b0);
        do_alloc(32'h360, 1'b0);
        do_ack(mk_pld(32'h300));
        i_alloc_vld     = 1'b1;
        i_alloc_pc      = 32'h3E0;
        i_fe_ctrl_flush = 1'b1;
        tick();
        idle_inputs();
        check("t3_stale",    64'(o_stale_cnt), 64'd4);
        check("t3_cnt",      64'(o_cnt),       64'd0);
        check("t3_out_vld",  64'(o_out_vld),   64'd0);
        check("t3_alloc_id", 64'(o_alloc_id),  64'd0);
        do_alloc(32'h380, 1'b1);
        check("t3_new_cnt", 64'(o_cnt), 64'd1);
        do_bp2(3'd0);
        for (int i = 0; i < 4; i++) do_ack(~mk_pld(32'h3000 + 32'(i)));
        check("t3_stale_done", 64'(o_stale_cnt), 64'd0);
        check("t3_junk_hidden", 64'(o_out_vld), 64'd0);
        do_ack(mk_pld(32'h380));
        drain("t3_drain");

        // 4: BP2 flush squashes ids 2..4, which then retire silently
        do_reset();
        for (int i = 0; i < 5; i++) do_alloc(32'h400 + 32'(i) * 32'h20, i < 2);
        i_bp2_flush    = 1'b1;
        i_bp2_flush_id = 3'd1;
        tick();
        i_bp2_flush = 1'b0;
        do_bp2(3'd3);
        for (int i = 0; i < 5; i++) do_ack(mk_pld(32'h400 + 32'(i) * 32'h20));
        check("t4_hold", 64'(o_out_vld), 64'd0);
        do_bp2(3'd0);
        do_bp2(3'd1);
        drain("t4_drain");
        repeat (4) tick();
        check("t4_cnt_empty", 64'(o_cnt),     64'd0);
        check("t4_out_idle",  64'(o_out_vld), 64'd0);

        // 5: ack + bp2 + flush on the head entry in one cycle
        do_reset();
        do_alloc(32'h500, 1'b0);
        do_alloc(32'h520, 1'b0);
        i_icache_ack_vld = 1'b1;
        i_icache_ack_pld = mk_pld(32'h500);
        i_bp2_vld        = 1'b1;
        i_bp2_id         = 3'd0;
        i_fe_ctrl_flush  = 1'b1;
        tick();
        idle_inputs();
        check("t5_out_vld", 64'(o_out_vld),   64'd0);
        check("t5_stale",   64'(o_stale_cnt), 64'd1);
        check("t5_cnt",     64'(o_cnt),       64'd0);
        tick();
        check("t5_out_vld_later", 64'(o_out_vld), 64'd0);
        do_ack(~mk_pld(32'h520));
        check("t5_stale_done", 64'(o_stale_cnt), 64'd0);

        // 6: wrapped window head=6, tail=2; BP2 flush at id 7 squashes 0 and 1
        do_reset();
        for (int i = 0; i < 6; i++) do_alloc(32'h600 + 32'(i) * 32'h20, 1'b1);
        for (int i = 0; i < 6; i++) do_ack(mk_pld(32'h600 + 32'(i) * 32'h20));
        for (int i = 0; i < 6; i++) do_bp2(IDW'(i));
        drain("t6_pre_drain");
        check("t6_tail_at_6", 64'(o_alloc_id), 64'd6);
        for (int i = 0; i < 4; i++) do_alloc(32'h700 + 32'(i) * 32'h20, i < 2);
        check("t6_tail_wrap", 64'(o_alloc_id), 64'd2);
        check("t6_cnt",       64'(o_cnt),      64'd4);
        i_bp2_flush    = 1'b1;
        i_bp2_flush_id = 3'd7;
        tick();
        i_bp2_flush = 1'b0;
        for (int i = 0; i < 4; i++) do_ack(mk_pld(32'h700 + 32'(i) * 32'h20));
        do_bp2(3'd6);
        do_bp2(3'd7);
        do_bp2(3'd0);
        do_bp2(3'd1);
        drain("t6_drain");
        repeat (4) tick();
        check("t6_cnt_empty", 64'(o_cnt), 64'd0);

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
